seg_scan4: RTL and testbench
============================

# seg_scan4

Four-digit seven-segment scan driver for the EGo1 display. It is the stage directly downstream of the seconds counter and BCD split. It takes a 16-bit packed BCD/hex word plus decimal points and time-multiplexes it onto the shared segment bus and the four digit selects. It adds frame-aligned update, anti-ghosting dead time, and optional leading-zero blanking.

## Interface
- `SCAN_DIV`, default 100_000: clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range ≥ 4.
- `DEAD_CYC`, default 1_000: cycles at the start of each slot with all selects off; legal range 0 ≤ DEAD_CYC < SCAN_DIV.
- `clk  in  1`: single clock; all logic on rising edge.
- `rst  in  1`: reset, synchronous, active-low.
- `data  in  16`: nibble per digit; [3:0] = rightmost digit (cs[0]), [15:12] = leftmost (cs[3]).
- `dp  in  4`: decimal point per digit; same bit-to-digit mapping as `data`.
- `load  in  1`: one-cycle strobe; captures `data`/`dp` into the pending register.
- `seg_data  out  8`: segments, active-high; bit0=a … bit6=g, bit7=dp.
- `seg_cs  out  4`: digit selects, active-high, at most one bit set.
- `frame_tick  out  1`: one-cycle pulse when the slot for digit 0 begins.

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 and wraps. At wrap, digit index `dig` (2 bits) advances 0→1→2→3→0.
- Pending register: loaded on any cycle with `load`=1. The latest load wins.
- Shadow register (the displayed value): copied from pending when `dig` wraps 3→0. The display never changes mid-frame.
- If `load`=1 in the same cycle as the 3→0 wrap, shadow takes the new `data`/`dp` directly (bypass), and pending also takes it.
- Slot output:
  - If `div_cnt` < DEAD_CYC: `seg_cs`=0 and `seg_data`=0.
  - Otherwise: `seg_cs`=one-hot(`dig`) and `seg_data`={dp bit, decode(nibble)}.
- Decode, a..g as hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, b=7C, C=39, d=5E, E=79, F=71
  - Nibbles 10–15 are legal and display as hex.
- `frame_tick`=1 for exactly the one cycle in which the registered outputs first reflect `dig`=0, `div_cnt`=0.
- Reset (rst=0 at a clock edge) clears the following: `div_cnt`, `dig`, pending, shadow, `seg_data`=0, `seg_cs`=0, `frame_tick`=0.
  - Reset mid-slot or mid-frame aborts immediately.
  - The first slot after release is digit 0 and starts with its dead time.

## Timing
- All outputs are registered: they are a function of (`div_cnt`, `dig`, shadow) from the previous cycle, a 1-cycle latency.
- First cycle after reset release: outputs still 0.
- Outputs for digit 0 become active (when DEAD_CYC=0) or first go through dead time at the next edge.
- Slot length is exactly SCAN_DIV cycles. Frame length is exactly 4·SCAN_DIV cycles. Select-active time per slot is SCAN_DIV−DEAD_CYC cycles.
- Load-to-display latency:
  - At least 1 cycle (bypass case).
  - At most 4·SCAN_DIV + 1 cycles.
  - The value appears at the next frame start.
- `seg_cs` never has two bits set. Between two different active selects there are always DEAD_CYC cycles of 0, including across the 3→0 wrap.

## Configuration
- Macro `SEG_LZ_BLANK_EN`, defined: leading-zero blanking is enabled.
  - Digit k (k=3..1) is blanked when its shadow nibble and all higher nibbles are 0 and its dp bit is 0.
  - A blanked slot drives `seg_cs`=0 and `seg_data`=0 for the whole slot.
  - Digit 0 is never blanked.
  - Slot timing and `frame_tick` are unchanged.
- Macro `SEG_LZ_BLANK_EN`, undefined: all four digits are always driven. Value 0000 shows "0000".

## Test plan
- Reset/idle: hold rst=0 for 5 cycles. Expect `seg_cs`=0, `seg_data`=0, `frame_tick`=0. After release with SCAN_DIV=8, DEAD_CYC=2, expect:
  - the first `frame_tick` on the first post-release output cycle;
  - `seg_cs`=0001 from cycle 3 to cycle 8 of the slot.
- Scan/decode: load data=16'h1234, dp=4'b0100, then wait one frame. Expect per slot:
  - cs=0001 → seg=4'h66 code (8'h66);
  - cs=0010 → 8'h4F;
  - cs=0100 → 8'hDB (2 with dp);
  - cs=1000 → 8'h06.
- Frame alignment: load 16'h1111 mid-slot of digit 1, then load 16'h2222 two cycles later. Expect:
  - the rest of the frame unchanged;
  - the next frame shows 2222 only (the 1111 value is never displayed).
- Bypass: assert `load` with 16'h9876 exactly on the 3→0 wrap cycle. Expect the digit-0 slot in the same frame to show 8'h7D.
- Reset mid-operation: drop rst while cs=0100. Expect all outputs 0 on the next edge. After release, expect the scan restarts at digit 0 with shadow=0.
- Blanking, with `SEG_LZ_BLANK_EN`:
  - data=16'h0042, dp=0 → slots 3 and 2 fully dark, slot 1=8'h66, slot 0=8'h5B;
  - data=0, dp=4'b1000 → all four digits lit: 8'hBF, 8'h3F, 8'h3F, 8'h3F.

Source files
------------

// File: rtl/seg_scan4.sv
// -----------------------------------------------------------------------------
// seg_scan4 - four-digit seven-segment scan driver (EGo1 display)
//
// Takes a 16-bit packed nibble word plus four decimal points and multiplexes it
// onto the shared segment bus and four digit selects. New values are captured
// into a pending register on `load` and only promoted to the displayed
// (shadow) value at a frame boundary, so a frame is never torn. Each digit slot
// starts with DEAD_CYC cycles of all-dark output to suppress ghosting.
//
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (>= 4)
//   DEAD_CYC   dark cycles at the start of every slot (0 <= DEAD_CYC < SCAN_DIV)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   data[15:0]  nibble per digit, [3:0] = rightmost digit (seg_cs[0])
//   dp[3:0]     decimal point per digit, same mapping as data
//   load        one-cycle strobe capturing data/dp into the pending register
//   seg_data    segments a..g in bits 0..6, dp in bit 7, active high
//   seg_cs      digit selects, active high, at most one bit set
//   frame_tick  one-cycle pulse when the digit-0 slot begins on the outputs
//
// Configuration macro:
//   SEG_LZ_BLANK_EN  when defined, leading zero digits (3..1) are kept dark
// -----------------------------------------------------------------------------
module seg_scan4 #(
    parameter int SCAN_DIV = 100_000,
    parameter int DEAD_CYC = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic [7:0]  seg_data,
    output logic [3:0]  seg_cs,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(SCAN_DIV - 1);

    cnt_t        div_cnt_q, div_cnt_d;
    logic [1:0]  dig_q, dig_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic [15:0] shad_data_q, shad_data_d;
    logic [3:0]  shad_dp_q, shad_dp_d;
    logic [7:0]  seg_data_q, seg_data_d;
    logic [3:0]  seg_cs_q, seg_cs_d;
    logic        frame_tick_q, frame_tick_d;

    logic        cnt_wrap;
    logic        frame_wrap;
    logic        in_dead;
    logic [3:0]  cur_nib;
    logic [3:0]  blank;

    function automatic logic [6:0] decode7(input logic [3:0] nib);
        decode7 = 7'h00;
        case (nib)
            4'h0: decode7 = 7'h3F;
            4'h1: decode7 = 7'h06;
            4'h2: decode7 = 7'h5B;
            4'h3: decode7 = 7'h4F;
            4'h4: decode7 = 7'h66;
            4'h5: decode7 = 7'h6D;
            4'h6: decode7 = 7'h7D;
            4'h7: decode7 = 7'h07;
            4'h8: decode7 = 7'h7F;
            4'h9: decode7 = 7'h6F;
            4'hA: decode7 = 7'h77;
            4'hB: decode7 = 7'h7C;
            4'hC: decode7 = 7'h39;
            4'hD: decode7 = 7'h5E;
            4'hE: decode7 = 7'h79;
            4'hF: decode7 = 7'h71;
            default: decode7 = 7'h00;
        endcase
    endfunction

`ifdef SEG_LZ_BLANK_EN
    // lz[k]: digit k shows nothing meaningful (zero nibble, no dp). A digit is
    // blanked only if it and every digit to its left are such zeros, so a lit
    // dp on a higher digit stops the blanking below it.
    logic [3:1] lz;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign lz[gi]    = (shad_data_q[gi*4 +: 4] == 4'h0) && !shad_dp_q[gi];
            assign blank[gi] = &lz[3:gi];
        end
    endgenerate
    assign blank[0] = 1'b0;
`else
    assign blank = 4'b0000;
`endif

    always_comb begin
        cnt_wrap   = (div_cnt_q == CNT_LAST);
        frame_wrap = cnt_wrap && (dig_q == 2'd3);

        div_cnt_d = cnt_wrap ? cnt_t'(0) : div_cnt_q + cnt_t'(1);
        dig_d     = cnt_wrap ? dig_q + 2'd1 : dig_q;

        pend_data_d = load ? data : pend_data_q;
        pend_dp_d   = load ? dp   : pend_dp_q;

        // pend_*_d already carries a same-cycle load, which gives the bypass.
        shad_data_d = frame_wrap ? pend_data_d : shad_data_q;
        shad_dp_d   = frame_wrap ? pend_dp_d   : shad_dp_q;

        in_dead = (int'(div_cnt_q) < DEAD_CYC);
        cur_nib = shad_data_q[{dig_q, 2'b00} +: 4];

        seg_cs_d   = 4'b0000;
        seg_data_d = 8'h00;
        if (!in_dead && !blank[dig_q]) begin
            seg_cs_d   = 4'b0001 << dig_q;
            seg_data_d = {shad_dp_q[dig_q], decode7(cur_nib)};
        end

        frame_tick_d = (dig_q == 2'd0) && (div_cnt_q == cnt_t'(0));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q    <= cnt_t'(0);
            dig_q        <= 2'd0;
            pend_data_q  <= 16'h0000;
            pend_dp_q    <= 4'h0;
            shad_data_q  <= 16'h0000;
            shad_dp_q    <= 4'h0;
            seg_data_q   <= 8'h00;
            seg_cs_q     <= 4'h0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_q        <= dig_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            shad_data_q  <= shad_data_d;
            shad_dp_q    <= shad_dp_d;
            seg_data_q   <= seg_data_d;
            seg_cs_q     <= seg_cs_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_data   = seg_data_q;
    assign seg_cs     = seg_cs_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan4.sv
// -----------------------------------------------------------------------------
// tb_seg_scan4 - self-checking bench for seg_scan4 (SCAN_DIV=8, DEAD_CYC=2).
// Expected per-slot display values are queued when a load is driven and popped
// by a monitor at the first active cycle of each slot, then held for the whole
// active window. Dead time and frame_tick are checked on every cycle.
// Build with +define+SEG_LZ_BLANK_EN to exercise leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_seg_scan4;

    localparam int SCAN_DIV = 8;
    localparam int DEAD_CYC = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic        load = 1'b0;
    logic [7:0]  seg_data;
    logic [3:0]  seg_cs;
    logic        frame_tick;

    seg_scan4 #(
        .SCAN_DIV (SCAN_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp         (dp),
        .load       (load),
        .seg_data   (seg_data),
        .seg_cs     (seg_cs),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         frame;
        int         slot;
        logic [3:0] cs;
        logic [7:0] seg;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    logic have_exp = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    // Index of the last clock edge since reset release (-1 while in reset).
    int edge_cnt = -1;
    int mk, mp, ms, mf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[nib];
    endfunction

    // Queue the four slot expectations of frame f showing d/dpv.
    task automatic push_frame(input int f, input logic [15:0] d, input logic [3:0] dpv);
        logic [3:0] blank;
        logic       lead;
        exp_t       e;
        blank = 4'b0000;
        lead  = 1'b1;
`ifdef SEG_LZ_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (lead && d[i*4 +: 4] == 4'h0 && !dpv[i]) blank[i] = 1'b1;
            else lead = 1'b0;
        end
`endif
        for (int s = 0; s < 4; s++) begin
            e.frame = f;
            e.slot  = s;
            if (blank[s]) begin
                e.cs  = 4'b0000;
                e.seg = 8'h00;
            end else begin
                e.cs  = 4'(1 << s);
                e.seg = {dpv[s], seg7(d[s*4 +: 4])};
            end
            sb_q.push_back(e);
        end
    endtask

    // Drive load so that it is sampled by edge index k.
    task automatic load_at(input int k, input logic [15:0] d, input logic [3:0] dpv);
        while (edge_cnt < k - 1) @(negedge clk);
        data = d;
        dp   = dpv;
        load = 1'b1;
        $display("load at edge %0d: data=%04h dp=%04b", k, d, dpv);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_edge(input int k);
        while (edge_cnt < k) @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst) edge_cnt = -1;
        else      edge_cnt = edge_cnt + 1;
    end

    // Slot monitor: outputs after edge k reflect scan position k.
    always @(negedge clk) begin
        if (edge_cnt >= 0) begin
            mk = edge_cnt;
            mp = mk % SCAN_DIV;
            ms = (mk / SCAN_DIV) % 4;
            mf = mk / FRAME;
            check_val($sformatf("frame_tick@%0d", mk), 32'(frame_tick), 32'(mp == 0 && ms == 0));
            if (mp < DEAD_CYC) begin
                have_exp = 1'b0;
                check_val($sformatf("dead@%0d", mk), 32'({seg_cs, seg_data}), 32'h0);
            end else begin
                if (mp == DEAD_CYC) begin
                    have_exp = 1'b0;
                    if (sb_q.size() > 0 && sb_q[0].frame == mf && sb_q[0].slot == ms) begin
                        cur      = sb_q.pop_front();
                        have_exp = 1'b1;
                        $display("slot f%0d s%0d: cs=%04b seg=%02h", mf, ms, seg_cs, seg_data);
                    end
                end
                if (have_exp)
                    check_val($sformatf("f%0d_s%0d@%0d", mf, ms, mk),
                              32'({seg_cs, seg_data}), 32'({cur.cs, cur.seg}));
            end
        end else begin
            have_exp = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset / idle
        repeat (5) @(negedge clk);
        check_val("rst_cs", 32'(seg_cs), 32'h0);
        check_val("rst_seg", 32'(seg_data), 32'h0);
        check_val("rst_tick", 32'(frame_tick), 32'h0);

        rst = 1'b1;
        // Scan/decode: shadow is 0 in frame 0, 1234 from frame 1.
        push_frame(0, 16'h0000, 4'b0000);
        push_frame(1, 16'h1234, 4'b0100);
        load_at(5, 16'h1234, 4'b0100);
        // Frame alignment: mid-frame loads leave frame 2 unchanged.
        push_frame(2, 16'h1234, 4'b0100);
        load_at(2 * FRAME + SCAN_DIV + 3, 16'h1111, 4'b0000);
        load_at(2 * FRAME + SCAN_DIV + 5, 16'h2222, 4'b0000);
        push_frame(3, 16'h2222, 4'b0000);
        // Bypass: load on the 3->0 wrap edge shows in the very next frame.
        push_frame(4, 16'h9876, 4'b0000);
        load_at(4 * FRAME - 1, 16'h9876, 4'b0000);

        // Reset mid-operation while digit 2 is lit.
        wait_edge(5 * FRAME + 2 * SCAN_DIV + 4);
        check_val("pre_rst_cs", 32'(seg_cs), 32'b0100);
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_cs", 32'(seg_cs), 32'h0);
        check_val("midrst_seg", 32'(seg_data), 32'h0);
        check_val("midrst_tick", 32'(frame_tick), 32'h0);
        check_val("sb_drained", 32'(sb_q.size()), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Restart from digit 0 with cleared shadow and pending.
        push_frame(0, 16'h0000, 4'b0000);
        push_frame(1, 16'h0000, 4'b0000);
        push_frame(2, 16'h0042, 4'b0000);
        load_at(FRAME + 8, 16'h0042, 4'b0000);
        push_frame(3, 16'h0000, 4'b1000);
        load_at(2 * FRAME + 8, 16'h0000, 4'b1000);

        wait_edge(4 * FRAME + 1);
        @(negedge clk);
        check_val("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
